// File: rtl/board_mode_controller.sv
// Mode sequencer for the DE-board test design: debounced enter button, save/read FSM, LED/7-seg drive.
// Optional build macro AUTO_RETURN_EN adds an inactivity timeout that returns the FSM to IDLE.
module board_mode_controller #(
    parameter int ADDR_W          = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       enter_bar,
    input  logic [9:0] sw,
    output logic [9:0] disp_value,
    output logic [7:0] LEDG,
    output logic [1:0] mode,
    output logic       press
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SAVE_ADDR = 3'd1,
        S_SAVE_DATA = 3'd2,
        S_READ_ADDR = 3'd3,
        S_READ_SHOW = 3'd4
    } state_t;

    logic            sync1_q, sync2_q, stable_q, press_q, armed_q;
    logic [1:0]      prime_q;
    logic [DB_W-1:0] db_cnt_q;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [9:0]        mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic              timeout_hit;

    // armed_q stays low until the synchronized button is seen released after reset,
    // so a button held through reset release cannot produce a press.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
            prime_q  <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            sync1_q <= ~enter_bar;
            sync2_q <= sync1_q;
            prime_q <= {prime_q[0], 1'b1};
            if (prime_q[1] && !sync2_q)
                armed_q <= 1'b1;
            press_q <= 1'b0;
            if (sync2_q == stable_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                stable_q <= sync2_q;
                db_cnt_q <= '0;
                press_q  <= sync2_q & armed_q;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign press = press_q;

`ifdef AUTO_RETURN_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            to_flag_q;

    assign timeout_hit = (state_q != S_IDLE) && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_flag_q <= timeout_hit && !press_q;
            if (state_q == S_IDLE || press_q || timeout_hit)
                to_cnt_q <= '0;
            else
                to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE:
                    if (press_q) state_q <= sw[9] ? S_READ_ADDR : S_SAVE_ADDR;
                S_SAVE_ADDR:
                    if (press_q) begin
                        addr_q  <= sw[ADDR_W-1:0];
                        state_q <= S_SAVE_DATA;
                    end
                S_SAVE_DATA:
                    if (press_q) begin
                        mem_q[addr_q]   <= sw;
                        valid_q[addr_q] <= 1'b1;
                        state_q         <= S_IDLE;
                    end
                S_READ_ADDR:
                    if (press_q) begin
                        addr_q  <= sw[ADDR_W-1:0];
                        state_q <= S_READ_SHOW;
                    end
                S_READ_SHOW:
                    if (press_q) state_q <= S_IDLE;
                default:
                    state_q <= S_IDLE;
            endcase
            // A timeout only ever abandons a state; the write above needs press_q.
            if (!press_q && timeout_hit)
                state_q <= S_IDLE;
        end
    end

    always_comb begin
        disp_value = sw;
        LEDG       = 8'b1010_1010;
        mode       = 2'd0;
        case (state_q)
            S_SAVE_ADDR: begin LEDG = 8'b0000_0001; mode = 2'd1; end
            S_SAVE_DATA: begin LEDG = 8'b0000_0010; mode = 2'd1; end
            S_READ_ADDR: begin LEDG = 8'b0000_0100; mode = 2'd2; end
            S_READ_SHOW: begin
                mode = 2'd2;
                if (valid_q[addr_q]) begin
                    disp_value = mem_q[addr_q];
                    LEDG       = 8'b0000_1000;
                end else begin
                    disp_value = 10'd0;
                    LEDG       = 8'b1000_1000;
                end
            end
            default: ;
        endcase
`ifdef AUTO_RETURN_EN
        if (to_flag_q)
            LEDG[6] = 1'b1;
`endif
    end
endmodule

// File: doc/board_mode_controller.md
Name: board_mode_controller

Overview:
Top-level mode sequencer for the DE-board test design. It debounces the active-low enter button and steps a mode FSM: IDLE, DATA SAVE (address, then data) and DATA READ (address, then show). Saved 10-bit switch values go into a small internal register file. The block drives the green LEDs and supplies the 10-bit value shown by the existing four-digit 7-segment decoder.

Parameters:
ADDR_W, 3, register-file address width; depth = 2**ADDR_W entries of 10 bits.
DEBOUNCE_CYCLES, 500000, clk_50M cycles the synchronized button must hold a new level before it is accepted (10 ms).
TIMEOUT_CYCLES, 500000000, idle-button cycles before auto-return; used only with AUTO_RETURN_EN.

Ports:
clk_50M  in  1  system clock, 50 MHz
rst  in  1  reset, asynchronous, active-high
enter_bar  in  1  raw enter pushbutton, active-low, asynchronous to clk_50M
sw  in  10  slide switches: address/data source and mode select
disp_value  out  10  value passed to the 7-segment decoder
LEDG  out  8  green LED status pattern
mode  out  2  0=IDLE, 1=SAVE, 2=READ
press  out  1  debounced press pulse, one cycle (debug/chaining)

Behaviour:
- Button path: ~enter_bar goes through a 2-flop synchronizer. A stable-level register plus counter update it.
  - Counter resets when the synced level equals the stable level; otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1, stable takes the synced level and the counter clears.
  - press = 1 for exactly one cycle on a stable 0->1 transition. Release generates nothing.
  - Press latency from the raw edge is 2 + DEBOUNCE_CYCLES cycles.
- All FSM transitions occur only on press. No other input advances state.
- FSM states:
  - IDLE: LEDG=8'b10101010; disp_value=sw; mode=0. On press: sw[9]=0 -> SAVE_ADDR, sw[9]=1 -> READ_ADDR.
  - SAVE_ADDR: LEDG=8'b00000001; disp_value=sw; mode=1. On press: addr<=sw[ADDR_W-1:0] -> SAVE_DATA.
  - SAVE_DATA: LEDG=8'b00000010; disp_value=sw; mode=1. On press: mem[addr]<=sw, valid[addr]<=1 -> IDLE.
  - READ_ADDR: LEDG=8'b00000100; disp_value=sw; mode=2. On press: addr<=sw[ADDR_W-1:0] -> READ_SHOW.
  - READ_SHOW: mode=2.
    - If valid[addr]: disp_value=mem[addr], LEDG=8'b00001000.
    - Else: disp_value=10'd0, LEDG=8'b10001000 (LEDG[7] flags an empty entry).
    - On press -> IDLE.
  - Illegal state encoding -> IDLE on the next clock.
- Outputs are combinational from state, mem/valid and sw. No added latency.
- Address width: sw bits above ADDR_W-1 are ignored, so addresses wrap modulo depth.
- Writing an address again overwrites it; the last write wins.
- Write timing: a write in SAVE_DATA and the transition to IDLE happen on the same clock. A read of that entry on a later visit returns the new value.
- Reset (asynchronous, any time):
  - state=IDLE, addr=0, all valid=0, all mem=0.
  - Synchronizer and stable register = released (0), counter=0, press=0.
  - Resulting outputs: LEDG=8'b10101010, disp_value=sw, mode=0.
  - A save in progress is discarded with no write.
- A button held through reset release must produce no press until it has been released and pressed again.

Optional Feature:
AUTO_RETURN_EN
- Defined: an inactivity counter runs in every non-IDLE state.
  - It clears on each press and on entering IDLE.
  - On reaching TIMEOUT_CYCLES-1, the FSM returns to IDLE with no write.
  - LEDG[6]=1 for the first cycle in IDLE after a timeout return.
- Undefined: no counter is instantiated, states persist indefinitely, and LEDG[6] follows the state patterns above.

Test Plan:
- Reset asserted mid-SAVE_DATA with sw=10'h155 -> immediately LEDG=8'hAA, mode=0; READ of that address afterwards shows 0 with LEDG=8'h88.
- DEBOUNCE_CYCLES=4: enter_bar low glitch of 3 cycles -> no press; low for 10 cycles -> exactly one press pulse, 6 cycles after the falling edge; release -> no pulse.
- Save: sw=0 press, sw=10'h005 press, sw=10'h2A7 press -> IDLE. Then read: sw=10'h200 press, sw=10'h005 press -> disp_value=10'h2A7, LEDG=8'h08.
- Address wrap (ADDR_W=3): save 10'h0AB at sw=10'h00D -> read address 5 returns 10'h0AB.
- Overwrite: save 10'h001 then 10'h3FF to address 2 -> read address 2 gives 10'h3FF.
- With AUTO_RETURN_EN, TIMEOUT_CYCLES=20: enter SAVE_ADDR, no press -> IDLE after 20 cycles, LEDG=8'hEA for one cycle then 8'hAA, memory unchanged.
